// File: rtl/char_buf_ctrl.sv
// Character text buffer for the character-drawing stage: 256 x 7-bit storage
// indexed {col, row}, a host byte-stream writer with an auto-advancing cursor,
// and a clear sequencer that fills the buffer with CLR_CODE during blanking.
module char_buf_ctrl #(
  parameter logic [6:0] CLR_CODE = 7'h20,
  parameter logic [7:0] NL_CODE  = 8'h0A,
  parameter logic [7:0] FF_CODE  = 8'h0C
) (
  input  logic       pclk,
  input  logic       rst,
  input  logic [7:0] disp_addr,
  input  logic       disp_blnk,
  output logic [6:0] disp_code,
  input  logic       wr_valid,
  input  logic [7:0] wr_char,
  output logic       wr_ready,
  input  logic       clr_req,
  output logic       busy,
  output logic [7:0] cursor
);

  localparam int unsigned DEPTH = 256;

  typedef enum logic {
    IDLE,
    CLEAR
  } state_t;

  state_t     state;
  logic [7:0] clr_addr;
  logic [6:0] mem [DEPTH];

  logic       accept;
  logic       is_nl;
  logic       is_ff;
  logic       mem_we;
  logic [7:0] mem_waddr;
  logic [6:0] mem_wdata;
  logic [3:0] col;
  logic [3:0] row;

  assign col      = cursor[7:4];
  assign row      = cursor[3:0];
  assign busy     = (state == CLEAR);
  assign wr_ready = (state == IDLE) && disp_blnk && !rst;
  assign accept   = wr_valid && wr_ready;
  assign is_nl    = (wr_char == NL_CODE);
  assign is_ff    = (wr_char == FF_CODE);

  // Single write port shared by the clear sequencer and the host stream
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = cursor;
    mem_wdata = wr_char[6:0];
    if (state == CLEAR) begin
      mem_we    = disp_blnk && !rst;
      mem_waddr = clr_addr;
      mem_wdata = CLR_CODE;
    end else begin
      mem_we    = accept && !is_nl && !is_ff;
    end
  end

  // Storage array; contents are initialised by the clear sequence, not by reset
  always_ff @(posedge pclk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Display read port, one-cycle latency, read-first against a same-cycle write
  always_ff @(posedge pclk) begin
    if (rst) begin
      disp_code <= 7'h00;
    end else begin
      disp_code <= mem[disp_addr];
    end
  end

  // Control FSM: host byte handling in IDLE, blanking-gated fill in CLEAR
  always_ff @(posedge pclk) begin
    if (rst) begin
      state    <= CLEAR;
      clr_addr <= 8'h00;
      cursor   <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (is_ff) begin
              cursor   <= 8'h00;
              clr_addr <= 8'h00;
              state    <= CLEAR;
            end else if (is_nl) begin
              cursor <= {4'h0, 4'(row + 4'd1)};
            end else begin
              cursor <= {4'(col + 4'd1), 4'(row + 4'(col == 4'hF))};
            end
          end
          if (clr_req) begin
            clr_addr <= 8'h00;
            state    <= CLEAR;
          end
        end
        CLEAR: begin
          if (disp_blnk) begin
            clr_addr <= 8'(clr_addr + 8'd1);
            if (clr_addr == 8'hFF) begin
              cursor <= 8'h00;
              state  <= IDLE;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: doc/char_buf_ctrl.md
Name: char_buf_ctrl

Overview:
- Controller and storage for the 16x16 character text buffer read by the character-drawing stage. The drawing stage presents char_xy on disp_addr and receives a 7-bit character code.
- A host byte stream with valid/ready handshake writes characters at an auto-advancing cursor. A clear sequencer fills the buffer with spaces.
- Host and clear writes only occur while the display is blanking, so the display read port is never disturbed.

Parameters:
- CLR_CODE, 7'h20, code written to every entry during clear.
- NL_CODE, 8'h0A, host byte that moves the cursor to column 0 of the next row.
- FF_CODE, 8'h0C, host byte that starts a clear and homes the cursor.

Ports:
- pclk  in  1  pixel clock.
- rst  in  1  synchronous, active-high reset.
- disp_addr  in  8  display read address {col[3:0], row[3:0]}.
- disp_blnk  in  1  high while hblnk or vblnk is high; write window.
- disp_code  out  7  registered character code at disp_addr.
- wr_valid  in  1  host byte valid.
- wr_char  in  8  host byte.
- wr_ready  out  1  host byte accepted this cycle when wr_valid is also high.
- clr_req  in  1  single-cycle clear request.
- busy  out  1  high while the CLEAR state is active.
- cursor  out  8  current write address {col, row}.

Behaviour:
- Storage: 256 x 7 bit array, indexed {col, row}. Contents are not reset; the clear sequence initialises them.
- Display read:
  - disp_code <= mem[disp_addr] every cycle, 1-cycle latency, independent of state.
  - Read-first: on a same-address write in the same cycle, disp_code returns the old data.
  - While rst is high, disp_code <= 0.
- FSM has two states, IDLE and CLEAR. rst forces CLEAR with clr_addr = 0 and cursor = 0, so busy = 1 from the first cycle after reset.
- busy = (state == CLEAR), combinational from state.
- wr_ready = (state == IDLE) && disp_blnk && !rst, combinational. A byte is accepted when wr_valid && wr_ready.
- IDLE, accepted byte handling:
  - wr_char == FF_CODE: no store; cursor <= 0, clr_addr <= 0, go to CLEAR next cycle.
  - wr_char == NL_CODE: no store; col <= 0, row <= row+1 (row 15 wraps to 0).
  - Any other byte: mem[cursor] <= wr_char[6:0], then col <= col+1.
    - col 15 wraps to col 0 with row+1.
    - {col 15, row 15} wraps to cursor 0.
- IDLE, clr_req:
  - clr_req high while in IDLE: go to CLEAR, clr_addr <= 0.
  - If a byte is accepted in the same cycle, the byte is processed first (store or cursor move) and the clear follows.
  - The clear then overwrites the stored byte and sets cursor to 0 on completion.
- CLEAR:
  - In each cycle with disp_blnk = 1: mem[clr_addr] <= CLR_CODE and clr_addr <= clr_addr+1.
  - With disp_blnk = 0: the sequencer holds clr_addr and does not write.
  - After the write to address 255: cursor <= 0, go to IDLE next cycle.
  - A full clear takes exactly 256 blanking cycles.
  - clr_req and wr_valid are ignored in CLEAR; wr_ready stays 0.
- Reset mid-clear or mid-stream: the clear restarts from address 0 and cursor returns to 0. Partial contents are irrelevant because they are overwritten.
- Host writes complete in the acceptance cycle. The new data is visible on disp_code 1 cycle after disp_addr selects it, in any later cycle.
- No back-pressure beyond wr_ready. A wr_valid held with disp_blnk = 0 waits; the host must hold wr_char stable until accepted.

Test Plan:
- Reset, then disp_blnk held 1: busy = 1 for 256 cycles, then 0. Read of any address after that gives disp_code = 7'h20 one cycle after disp_addr is applied. cursor = 0.
- Idle with disp_blnk = 0 and wr_valid = 1, wr_char = 8'h41: wr_ready = 0, nothing stored. Raise disp_blnk: accepted that cycle, mem[0x00] = 7'h41, cursor = 8'h10.
- Write 16 bytes 8'h30..8'h3F from cursor 0: entries {col0..15, row0} hold codes 0x30..0x3F, and cursor = 8'h01 (col 0, row 1). Write 256 bytes in total: cursor wraps to 8'h00.
- cursor = 8'h53, send NL_CODE: cursor = 8'h04, no memory change. cursor = 8'h5F, send NL_CODE: cursor = 8'h00.
- Send FF_CODE with disp_blnk toggling 1 cycle on / 3 cycles off: busy stays high until exactly 256 blanking cycles have elapsed, wr_ready = 0 throughout, all entries = 7'h20 and cursor = 0 afterwards.
- Assert rst when clr_addr = 100: after release the clear restarts at 0 and takes a full 256 blanking cycles. Same-cycle write and display read of one address returns the old code, and the new code on the next read.
